mem_bus_mux: RTL

MEM_BUS_MUX -- requirements
Module: mem_bus_mux

---
 rtl/mem_bus_mux_pkg.sv | 27 ++
 rtl/mem_bus_dec.sv | 32 +++
 rtl/mem_bus_mux.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_mux_pkg.sv
// Shared definitions for the CPU-to-slave memory bus multiplexer.
package mem_bus_mux_pkg;

  // Transaction FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Address bit that separates RAM (0) from IO (1) in the default map.
  localparam int          IO_MAP_BIT = 22;
  localparam logic [31:0] RAM_BASE   = 32'h0000_0000;
  localparam logic [31:0] IO_BASE    = 32'h1 << IO_MAP_BIT;
  // Compare every bit at or above the IO map bit.
  localparam logic [31:0] MAP_MASK   = ~((32'h1 << IO_MAP_BIT) - 32'h1);

  // Read data returned on unmapped accesses and timeouts.
  localparam logic [31:0] ERR_RDATA  = 32'h0000_0000;

  // Width of a slave index; never zero so a single-slave build still has a bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mem_bus_dec.sv
// Combinational address decoder: lowest-index matching slave wins.
module mem_bus_dec
  import mem_bus_mux_pkg::*;
#(
  parameter int                    NUM_SLV  = 2,
  parameter logic [32*NUM_SLV-1:0] SLV_BASE = {IO_BASE, RAM_BASE},
  parameter logic [32*NUM_SLV-1:0] SLV_MASK = {MAP_MASK, MAP_MASK},
  parameter int                    IW       = 1
) (
  input  logic [31:0]        addr_i,
  output logic [NUM_SLV-1:0] hit_vec_o,
  output logic               hit_o,
  output logic [IW-1:0]      idx_o
);

  // Scan from the top down so the lowest matching index is the last write.
  always_comb begin
    hit_o     = 1'b0;
    idx_o     = '0;
    hit_vec_o = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--) begin
      if ((addr_i & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
        hit_o = 1'b1;
        idx_o = IW'(i);
      end
    end
    for (int i = 0; i < NUM_SLV; i++) begin
      hit_vec_o[i] = hit_o && (idx_o == IW'(i));
    end
  end

endmodule

// File: rtl/mem_bus_mux.sv
// Single-master memory bus multiplexer with address decode and ready timeout.
// Handshake: a CPU request is present when cpu_rstrb_i=1 or cpu_wmask_i!=0 and
// is only accepted while cpu_busy_o=0; the selected slave sees its strobes for
// exactly one cycle, completes by raising slv_ready_i[sel], and the CPU sees
// completion as a one-cycle cpu_done_o pulse with cpu_err_o/cpu_rdata_o valid.
module mem_bus_mux
  import mem_bus_mux_pkg::*;
#(
  parameter int                    NUM_SLV  = 2,
  parameter logic [32*NUM_SLV-1:0] SLV_BASE = {IO_BASE, RAM_BASE},
  parameter logic [32*NUM_SLV-1:0] SLV_MASK = {MAP_MASK, MAP_MASK},
  parameter int                    TIMEOUT  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [31:0]             cpu_addr_i,
  input  logic                    cpu_rstrb_i,
  input  logic [3:0]              cpu_wmask_i,
  input  logic [31:0]             cpu_wdata_i,
  output logic [31:0]             cpu_rdata_o,
  output logic                    cpu_busy_o,
  output logic                    cpu_done_o,
  output logic                    cpu_err_o,
  output logic [32*NUM_SLV-1:0]   slv_addr_o,
  output logic [NUM_SLV-1:0]      slv_rstrb_o,
  output logic [4*NUM_SLV-1:0]    slv_wmask_o,
  output logic [32*NUM_SLV-1:0]   slv_wdata_o,
  input  logic [32*NUM_SLV-1:0]   slv_rdata_i,
  input  logic [NUM_SLV-1:0]      slv_ready_i
);

  localparam int IW = idx_width(NUM_SLV);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e               state_q, state_d;
  logic [31:0]          addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           wmask_q, wmask_d;
  logic                 rstrb_q, rstrb_d;
  logic [IW-1:0]        sel_q, sel_d;
  logic [NUM_SLV-1:0]   sel_oh_q, sel_oh_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 err_q, err_d;
  logic                 done_q, done_d;

  logic                 req;
  logic [NUM_SLV-1:0]   hit_vec;
  logic                 hit;
  logic [IW-1:0]        hit_idx;
  logic                 sel_ready;
  logic [31:0]          sel_rdata;
  logic [CW-1:0]        cnt_inc;
  logic                 timeout_hit;

  mem_bus_dec #(
    .NUM_SLV  (NUM_SLV),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK),
    .IW       (IW)
  ) u_dec (
    .addr_i    (cpu_addr_i),
    .hit_vec_o (hit_vec),
    .hit_o     (hit),
    .idx_o     (hit_idx)
  );

  assign req       = cpu_rstrb_i | (|cpu_wmask_i);
  assign sel_ready = |(slv_ready_i & sel_oh_q);
  assign sel_rdata = slv_rdata_i[32*int'(sel_q) +: 32];
  // Saturating increment; the timeout fires on the cycle the count would reach TIMEOUT.
  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
  assign timeout_hit = (TIMEOUT != 0) && (cnt_inc == CW'(TIMEOUT));

  // Next-state and datapath update for the transaction FSM.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    wmask_d  = wmask_q;
    rstrb_d  = rstrb_q;
    sel_d    = sel_q;
    sel_oh_d = sel_oh_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d   = cpu_addr_i;
          wdata_d  = cpu_wdata_i;
          wmask_d  = cpu_wmask_i;
          rstrb_d  = cpu_rstrb_i;
          sel_d    = hit_idx;
          sel_oh_d = hit_vec;
          if (hit) begin
            state_d = ST_ISSUE;
          end else begin
            state_d = ST_DONE;
            rdata_d = ERR_RDATA;
            err_d   = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        // Ready seen here belongs to no request yet and is ignored.
        cnt_d   = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (sel_ready) begin
          rdata_d = sel_rdata;
          err_d   = 1'b0;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          rdata_d = ERR_RDATA;
          err_d   = 1'b1;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched-request registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      wmask_q  <= '0;
      rstrb_q  <= 1'b0;
      sel_q    <= '0;
      sel_oh_q <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
      rstrb_q  <= rstrb_d;
      sel_q    <= sel_d;
      sel_oh_q <= sel_oh_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

  // Strobes reach only the selected slave, and only while in ISSUE.
  always_comb begin
    slv_rstrb_o = '0;
    slv_wmask_o = '0;
    if (state_q == ST_ISSUE) begin
      for (int i = 0; i < NUM_SLV; i++) begin
        slv_rstrb_o[i]       = sel_oh_q[i] & rstrb_q;
        slv_wmask_o[4*i +: 4] = sel_oh_q[i] ? wmask_q : 4'b0000;
      end
    end
  end

  assign slv_addr_o  = {NUM_SLV{addr_q}};
  assign slv_wdata_o = {NUM_SLV{wdata_q}};
  assign cpu_rdata_o = rdata_q;
  assign cpu_err_o   = err_q;
  assign cpu_done_o  = done_q;
  assign cpu_busy_o  = (state_q != ST_IDLE);

endmodule
